stream_accum32: RTL
===================

// Module: stream_accum32
// PURPOSE
//  Streaming accumulator sitting directly downstream of the 32-bit adder stage.
//  - Consumes a packet of 32-bit words over a valid/ready input.
//  - Sums the words modulo 2^WIDTH and presents the total, a sticky carry-out flag and a beat count on a valid/ready output.
//  - Converts the combinational add path into a registered, handshaked multi-cycle datapath.
// PARAMETERS
//  WIDTH  32  data/accumulator width in bits
//  CNT_W  8   beat counter width; saturates at 2^CNT_W-1
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       upstream word valid
//  in_ready   out  1       block can accept a word
//  in_data    in   WIDTH   word to accumulate
//  in_last    in   1       qualifies final word of packet
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_sum    out  WIDTH   packet sum mod 2^WIDTH
//  out_carry  out  1       sticky: any carry-out of bit WIDTH-1 during packet
//  out_count  out  CNT_W   words accepted in packet (saturating)
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk); rst is synchronous, active-high, sampled on the rising edge of clk.
//  - While rst=1 at an edge: state=IDLE, acc=0, carry=0, count=0, out_valid=0.
//  - in_ready=0 combinationally while rst=1.
//  Handshakes:
//  - Input beat accepted when in_valid & in_ready at a rising edge.
//  - Output transfer occurs when out_valid & out_ready at a rising edge.
//  - in_ready = (state != HOLD) & ~rst; combinational, and never depends on in_valid.
//  - in_data and in_last are ignored when no beat is accepted; gaps in in_valid are legal.
//  States (registered):
//  - IDLE: acc=0, count=0. An accepted beat sets acc=in_data, carry=0, count=1.
//    Next state is HOLD if in_last, else ACC.
//  - ACC: an accepted beat sets {c,acc}=acc+in_data (WIDTH+1-bit add), carry|=c, count+=1 (saturating).
//    Next state is HOLD if in_last, else stay in ACC.
//  - HOLD: out_valid=1; out_sum, out_carry and out_count stay stable until out_ready.
//    On output transfer: go to IDLE, clear acc, carry and count. No input is accepted in HOLD.
//  Timing and outputs:
//  - Latency: out_valid rises the cycle after the in_last beat is accepted. Throughput: 1 word/cycle.
//  - Minimum packet cost is 2 cycles (accept, then HOLD). There is no same-cycle result-out/new-word-in.
//  - out_sum, out_carry and out_count are driven directly from registers. When out_valid=0 they mirror
//    the running values and carry no meaning.
//  Boundary cases:
//  - Wrap-around: the sum wraps mod 2^WIDTH and out_carry records it. 0xFFFFFFFF+1 gives sum 0, carry 1.
//  - Single-word packet (in_last on first beat): out_sum=in_data, out_count=1, out_carry=0.
//  - Count saturation: out_count holds at 2^CNT_W-1; the sum keeps accumulating.
//  - rst mid-packet or in HOLD: the partial or pending result is discarded with no output. Resume in IDLE.
//  - in_valid held high during HOLD: nothing is accepted, and the word must still be presented after HOLD exits.
// STRUCTURE
//  - Shared package/include holds:
//    - state encodings IDLE=2'd0, ACC=2'd1, HOLD=2'd2 (2'd3 is illegal and recovers to IDLE);
//    - default WIDTH/CNT_W constants.
//  - One sub-module, add_carry_w: combinational WIDTH-bit adder with cin and cout,
//    instantiated once with cin=0 and a=(state==IDLE ? 0 : acc).
//  - The top level contains the FSM, acc/carry/count registers and handshake logic only.
// TESTING
//  1. Reset: rst=1 for 3 cycles, then 0 -> out_valid=0, out_sum=0, out_count=0, in_ready=1 in the first cycle after.
//  2. Words 1,2,3 (last on 3), back-to-back, out_ready=1 -> out_sum=6, out_count=3, out_carry=0;
//     out_valid high exactly one cycle, starting the cycle after word 3.
//  3. Words 0xFFFFFFFF, 0x00000002 (last) -> out_sum=0x00000001, out_carry=1, out_count=2.
//  4. Backpressure: result pending, out_ready=0 for 5 cycles, in_valid=1 with 0x10 -> in_ready=0 and outputs
//     stable throughout. After out_ready, 0x10 (last) is accepted as a fresh packet -> out_sum=0x10, carry=0.
//  5. Single beat 0xDEADBEEF with last, plus a 2-cycle in_valid gap inside a 3-word packet 4,5,6
//     -> sums 0xDEADBEEF/count 1, then 15/count 3.
//  6. rst pulse after 2 beats (7,8) of a packet, then packet 5 (last) -> no output for 7+8; out_sum=5, out_count=1.

Source files
------------

// File: rtl/stream_accum32_pkg.sv
// Shared constants and state encoding for the streaming packet accumulator.
package stream_accum32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  // 2'd3 is unused; the FSM treats it as a fault and returns to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : stream_accum32_pkg

// File: rtl/stream_accum32_if.sv
// Word-in / result-out handshake bundle for stream_accum32.
interface stream_accum32_if
  import stream_accum32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );

endinterface : stream_accum32_if

// File: rtl/add_carry_w.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
module add_carry_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule : add_carry_w

// File: rtl/stream_accum32.sv
// Packet accumulator: sums words of a packet, then holds sum/carry/count
// on the output handshake until the consumer takes it.
module stream_accum32
  import stream_accum32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  stream_accum32_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat_in;
  logic             beat_out;

  assign bus.in_ready  = (state_q != ST_HOLD) && !rst;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;
  assign bus.out_count = count_q;

  assign beat_in  = bus.in_valid && bus.in_ready;
  assign beat_out = bus.out_valid && bus.out_ready;

  // The first beat of a packet starts from zero regardless of acc_q.
  assign add_a = (state_q == ST_IDLE) ? '0 : acc_q;

  add_carry_w #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i    (add_a),
    .b_i    (bus.in_data),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_in) begin
          acc_d   = add_sum;
          carry_d = 1'b0;
          count_d = CNT_ONE;
          state_d = bus.in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat_in) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_cout;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
          state_d = bus.in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (beat_out) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        carry_d = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

endmodule : stream_accum32
